// File: rtl/alu_issue_queue.sv
// Command FIFO and sequencer in front of the 16-bit ALU: issues one command at a
// time, waits the opcode-dependent latency, and returns the registered result with its tag.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_a,
  input  logic [15:0]                cmd_b,
  input  logic [3:0]                 cmd_op,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [3:0]                 alu_op,
  input  logic [31:0]                alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_result,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH):0]     count
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // the producer holds its payload stable while valid & !ready.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;

  logic [15:0]      a_mem   [DEPTH];
  logic [15:0]      b_mem   [DEPTH];
  logic [3:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]       wcnt;
  logic [TAG_W-1:0] cur_tag;
  logic             cur_err;

  logic push, pop, capture, empty;
  logic [15:0] head_a, head_b;
  logic [3:0]  head_op;
  logic        head_err;

  function automatic logic [1:0] lat_of(input logic [3:0] op);
    return (op == 4'b0010 || op == 4'b0011) ? 2'd2 : 2'd1;
  endfunction

  assign empty     = (count == '0);
  assign cmd_ready = (count < CNT_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head_a    = a_mem[rd_ptr];
  assign head_b    = b_mem[rd_ptr];
  assign head_op   = op_mem[rd_ptr];
  assign head_err  = (head_op > 4'b1010) || (head_op == 4'b0011 && head_b == 16'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == 2'd0) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage carries no reset: occupancy and pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= cmd_a;
      b_mem[wr_ptr]   <= cmd_b;
      op_mem[wr_ptr]  <= cmd_op;
      tag_mem[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_IDLE;
      wcnt       <= '0;
      cur_tag    <= '0;
      cur_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_op  <= head_op;
        cur_tag <= tag_mem[rd_ptr];
        cur_err <= head_err;
        wcnt    <= lat_of(head_op);
      end else if (state == WAIT && wcnt != 2'd0) begin
        wcnt <= wcnt - 2'd1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_tag    <= cur_tag;
        rsp_err    <= cur_err;
        rsp_valid  <= 1'b1;
        alu_op     <= OP_IDLE;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small registered ALU model
// (1-cycle simple ops, 2-cycle multiply/divide) behind the queue.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [15:0]      cmd_a = '0, cmd_b = '0;
  logic [3:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [15:0]      alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [31:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad = 0;

  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] tag_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .count(count)
  );

  // ALU model: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not, 8 inc,
  // 9 shl, 10 shr, others 0.
  function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:  return {16'd0, a} + {16'd0, b};
      4'd1:  return {16'd0, a} - {16'd0, b};
      4'd2:  return {16'd0, a} * {16'd0, b};
      4'd3:  return (b == 16'd0) ? 32'hDEAD_DEAD : {16'd0, a / b};
      4'd4:  return {16'd0, a & b};
      4'd5:  return {16'd0, a | b};
      4'd6:  return {16'd0, a ^ b};
      4'd7:  return {16'd0, ~a};
      4'd8:  return {16'd0, a} + 32'd1;
      4'd9:  return {15'd0, a, 1'b0};
      4'd10: return {17'd0, a[15:1]};
      default: return 32'd0;
    endcase
  endfunction

  logic        alu_rst;
  logic [31:0] r1, r2;
  assign alu_rst = ~reset;
  always_ff @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      r1 <= '0;
      r2 <= '0;
    end else begin
      r1 <= alu_f(alu_a, alu_b, alu_op);
      r2 <= r1;
    end
  end
  assign alu_result = (alu_op == 4'd2 || alu_op == 4'd3) ? r2 : r1;

  // driver: presents a command at a negedge, returns at the negedge after its accept edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (alu_op !== 4'hF) begin bad++; $display("FAIL reset_alu_op: got %h want f", alu_op); end
    total++; if (alu_a !== 16'd0 || alu_b !== 16'd0) begin bad++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
    total++; if (rsp_result !== 32'd0 || rsp_tag !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp: got %h/%h/%b want 0/0/0", rsp_result, rsp_tag, rsp_err); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add;
    int n;
    rsp_ready = 1'b1;
    send(16'd10, 16'd5, 4'd0, 4'd3);
    @(negedge clk);
    total++; if (alu_op !== 4'd0 || alu_a !== 16'd10 || alu_b !== 16'd5) begin bad++; $display("FAIL add_issue: got op %h a %0d b %0d want 0/10/5", alu_op, alu_a, alu_b); end
    wait_rsp(n);
    total++; if (n + 1 !== 3) begin bad++; $display("FAIL add_latency: got %0d edges want 3", n + 1); end
    total++; if (rsp_result !== 32'd15) begin bad++; $display("FAIL add_result: got %0d want 15", rsp_result); end
    total++; if (rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin bad++; $display("FAIL add_tag_err: got %0d/%b want 3/0", rsp_tag, rsp_err); end
    total++; if (alu_op !== 4'hF) begin bad++; $display("FAIL add_alu_op_idle: got %h want f", alu_op); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_mul_latency;
    rsp_ready = 1'b1;
    send(16'd10, 16'd3, 4'd2, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (alu_op !== 4'd2 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mul_hold_%0d: got op %h valid %b want 2/0", i, alu_op, rsp_valid); end
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mul_latency: got valid %b want 1 at edge 4", rsp_valid); end
    total++; if (rsp_result !== 32'd30 || rsp_tag !== 4'd1) begin bad++; $display("FAIL mul_result: got %0d tag %0d want 30 tag 1", rsp_result, rsp_tag); end
    @(negedge clk);
  endtask

  task automatic test_fill_backpressure;
    int n;
    rsp_ready = 1'b0;
    exp_q.push_back(32'd15);  tag_q.push_back(4'd10); send(16'd10,  16'd5,  4'd0, 4'd10);
    exp_q.push_back(32'd8);   tag_q.push_back(4'd11); send(16'd15,  16'd7,  4'd1, 4'd11);
    exp_q.push_back(32'd10);  tag_q.push_back(4'd12); send(16'd15,  16'd10, 4'd4, 4'd12);
    exp_q.push_back(32'd142); tag_q.push_back(4'd13); send(16'd134, 16'd8,  4'd6, 4'd13);
    exp_q.push_back(32'd46);  tag_q.push_back(4'd14); send(16'd45,  16'd0,  4'd8, 4'd14);
    total++; if (count !== 3'd4 || cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got count %0d ready %b want 4/0", count, cmd_ready); end
    cmd_valid = 1'b1; cmd_a = 16'd99; cmd_b = 16'd1; cmd_op = 4'd0; cmd_tag = 4'd15;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_no_overflow: got count %0d want 4", count); end
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd15) begin bad++; $display("FAIL fill_hold: got valid %b result %0d want 1/15", rsp_valid, rsp_result); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] er;
      logic [TAG_W-1:0] et;
      wait_rsp(n);
      er = exp_q.pop_front();
      et = tag_q.pop_front();
      if (i > 0) begin
        total++; if (n !== 2) begin bad++; $display("FAIL fill_throughput_%0d: got %0d want 2", i, n); end
      end
      total++; if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_tag !== et) begin bad++; $display("FAIL fill_rsp_%0d: got %b/%0d/%0d want 1/%0d/%0d", i, rsp_valid, rsp_result, rsp_tag, er, et); end
      @(negedge clk);
    end
    total++; if (count !== 3'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL fill_drain: got count %0d valid %b want 0/0", count, rsp_valid); end
  endtask

  task automatic test_simul_push_pop;
    int n;
    rsp_ready = 1'b0;
    exp_q.push_back(32'd3);  tag_q.push_back(4'd1); send(16'd1,  16'd2, 4'd0, 4'd1);
    exp_q.push_back(32'd16); tag_q.push_back(4'd2); send(16'd20, 16'd4, 4'd1, 4'd2);
    exp_q.push_back(32'd9);  tag_q.push_back(4'd3); send(16'd3,  16'd3, 4'd2, 4'd3);
    exp_q.push_back(32'd7);  tag_q.push_back(4'd4); send(16'd7,  16'd5, 4'd5, 4'd4);
    wait_rsp(n);
    total++; if (count !== 3'd3 || rsp_result !== 32'd3) begin bad++; $display("FAIL simul_pre: got count %0d result %0d want 3/3", count, rsp_result); end
    rsp_ready = 1'b1;
    exp_q.push_back(32'd101); tag_q.push_back(4'd5);
    send(16'd100, 16'd1, 4'd8, 4'd5);
    total++; if (count !== 3'd3 || rsp_valid !== 1'b0 || alu_op !== 4'd1) begin bad++; $display("FAIL simul_count: got count %0d valid %b op %h want 3/0/1", count, rsp_valid, alu_op); end
    void'(exp_q.pop_front());
    void'(tag_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      logic [31:0] er;
      logic [TAG_W-1:0] et;
      wait_rsp(n);
      er = exp_q.pop_front();
      et = tag_q.pop_front();
      total++; if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_tag !== et) begin bad++; $display("FAIL simul_rsp_%0d: got %b/%0d/%0d want 1/%0d/%0d", i, rsp_valid, rsp_result, rsp_tag, er, et); end
      @(negedge clk);
    end
    total++; if (count !== 3'd0 || exp_q.size() != 0) begin bad++; $display("FAIL simul_drain: got count %0d left %0d want 0/0", count, exp_q.size()); end
  endtask

  task automatic test_errors;
    int n;
    rsp_ready = 1'b1;
    send(16'd25, 16'd0, 4'd3, 4'd6);
    wait_rsp(n);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_tag !== 4'd6) begin bad++; $display("FAIL err_div0: got %b/%b/%0d want 1/1/6", rsp_valid, rsp_err, rsp_tag); end
    @(negedge clk);
    send(16'd25, 16'd5, 4'd3, 4'd7);
    wait_rsp(n);
    total++; if (rsp_err !== 1'b0 || rsp_result !== 32'd5) begin bad++; $display("FAIL err_div_ok: got err %b result %0d want 0/5", rsp_err, rsp_result); end
    @(negedge clk);
    send(16'd1, 16'd1, 4'b1100, 4'd8);
    wait_rsp(n);
    total++; if (rsp_err !== 1'b1 || rsp_result !== 32'd0) begin bad++; $display("FAIL err_illegal: got err %b result %0d want 1/0", rsp_err, rsp_result); end
    @(negedge clk);
    send(16'd8, 16'd0, 4'b1010, 4'd9);
    wait_rsp(n);
    total++; if (rsp_err !== 1'b0 || rsp_result !== 32'd4) begin bad++; $display("FAIL err_op10: got err %b result %0d want 0/4", rsp_err, rsp_result); end
    @(negedge clk);
    send(16'd9, 16'd9, 4'b1011, 4'd10);
    wait_rsp(n);
    total++; if (rsp_err !== 1'b1 || rsp_result !== 32'd0) begin bad++; $display("FAIL err_op11: got err %b result %0d want 1/0", rsp_err, rsp_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    int n;
    rsp_ready = 1'b1;
    send(16'd10, 16'd3, 4'd2, 4'd9);
    send(16'd4, 16'd4, 4'd0, 4'd11);
    total++; if (alu_op !== 4'd2 || count !== 3'd1) begin bad++; $display("FAIL rmid_pre: got op %h count %0d want 2/1", alu_op, count); end
    #2 reset = 1'b0;
    #1;
    total++; if (count !== 3'd0 || rsp_valid !== 1'b0 || alu_op !== 4'hF) begin bad++; $display("FAIL rmid_async: got count %0d valid %b op %h want 0/0/f", count, rsp_valid, alu_op); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || alu_op !== 4'hF) begin bad++; $display("FAIL rmid_no_replay_%0d: got valid %b op %h want 0/f", i, rsp_valid, alu_op); end
    end
    send(16'd7, 16'd1, 4'd0, 4'd2);
    wait_rsp(n);
    total++; if (n !== 3 || rsp_result !== 32'd8 || rsp_tag !== 4'd2) begin bad++; $display("FAIL rmid_after: got n %0d result %0d tag %0d want 3/8/2", n, rsp_result, rsp_tag); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_add;
    test_mul_latency;
    test_fill_backpressure;
    test_simul_push_pop;
    test_errors;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Command buffer and sequencer directly upstream of the 16-bit ALU.
- Accepts {operandA, operandB, opcode, tag} commands over a valid/ready handshake and stores them in a FIFO.
- Drives one command at a time onto the ALU inputs and holds it for the opcode-dependent ALU latency.
- Captures the ALU's registered 32-bit result and returns it with its tag and an error flag over a second valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- TAG_W, 4, width of the caller-supplied command tag.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset: clears all state while 0. The ALU's own active-high reset is driven at top level as ~reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept a command; combinational, equals (count < DEPTH).
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_op  in  4  ALU opcode.
- cmd_tag  in  TAG_W  caller tag, returned with the response.
- alu_a  out  16  registered, to ALU operandA.
- alu_b  out  16  registered, to ALU operandB.
- alu_op  out  4  registered, to ALU opcode.
- alu_result  in  32  ALU result output.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured ALU result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  1  opcode > 4'b1010, or opcode == 4'b0011 with cmd_b == 0.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (reset = 0):
  - FIFO empty; count = 0.
  - State = IDLE.
  - alu_a = 0, alu_b = 0, alu_op = 4'b1111 (undefined opcode, ALU produces 0).
  - rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rsp_err = 0.
- Reset mid-operation: in-flight and queued commands are discarded; nothing is replayed.
- FIFO push: occurs when cmd_valid & cmd_ready at a rising edge.
- FIFO pop: occurs on the edge the FSM loads a command into the alu_* registers.
- Simultaneous push and pop: count is unchanged and both operations complete. A push into an empty FIFO becomes poppable at the next edge, not the same edge.
- Pointers wrap modulo DEPTH.
- When count == DEPTH, cmd_ready = 0 and no push occurs, even if a pop happens on the same edge.
- Latency table, LAT(op):
  - 2 for op 4'b0010 and 4'b0011 (the ALU's two-stage multiply/divide path).
  - 1 for all other opcodes, including illegal ones.
- State machine:
  - IDLE: if FIFO non-empty, at the edge pop the head into alu_a/alu_b/alu_op, latch tag and err, set wcnt = LAT(op), go to WAIT. Otherwise alu_op = 4'b1111.
  - WAIT: alu_* held stable. If wcnt != 0, decrement. If wcnt == 0, at the edge capture rsp_result <= alu_result, drive rsp_tag/rsp_err, set rsp_valid <= 1, alu_op <= 4'b1111, go to RESP.
  - RESP: all rsp_* outputs held stable while rsp_valid & !rsp_ready.
    - On an edge with rsp_ready & FIFO non-empty: pop the next command into alu_* (as in IDLE), rsp_valid <= 0, go to WAIT.
    - On an edge with rsp_ready & FIFO empty: rsp_valid <= 0, go to IDLE.
- Timing: the result is captured at the (LAT+1)th edge after the pop edge.
- Acceptance to response: rsp_valid rises LAT+2 edges after the command's accept edge, when the queue is empty and the FSM is idle.
- Throughput: back-to-back with rsp_ready held at 1, one response every LAT+2 cycles.
- Error commands: rsp_err = 1, and the command is still issued. Illegal opcodes therefore return 0. Divide-by-zero returns whatever the ALU produces (X in simulation); the bench checks only rsp_err for that case.
- Responses are returned in command order; only one command is in flight at a time.

Test Plan:
- Single add: push {a=10, b=5, op=0, tag=3} with the queue empty and rsp_ready=1 -> rsp_valid after 3 edges; rsp_result=15, rsp_tag=3, rsp_err=0; alu_op returns to 4'b1111.
- Multiply latency: push {10, 3, op=2, tag=1} -> alu_op=2 held for 3 edges; rsp_valid 4 edges after accept; rsp_result=30.
- Fill and back-pressure: hold rsp_ready=0 and push 5 commands (add, sub 15-7, and 15&10, xor 134^8, inc 45) -> first in flight, 4 queued, count=4, cmd_ready=0. Then release rsp_ready -> responses 15, 8, 10, 142, 46 in order with matching tags.
- Simultaneous push/pop: with count=DEPTH-1, push on the same edge the FSM pops -> count unchanged, no entry lost or duplicated, pointer wrap verified.
- Errors: {a=25, b=0, op=3} -> rsp_err=1. {a=1, b=1, op=4'b1100} -> rsp_err=1, rsp_result=0.
- Reset mid-WAIT: assert reset=0 during a multiply -> count=0, rsp_valid=0, alu_op=4'b1111 immediately (asynchronous). After release, a new add {7, 1} -> rsp_result=8.
